// File: rtl/sha256_top.sv
// ---------------------------------------------------------------------------
// sha256_top
//   Fully unrolled SHA-256 compression pipeline. Each accepted 512-bit block
//   goes through 64 registered round stages and one final-addition register.
//   A new block can enter every cycle. Digests of non-final blocks are folded
//   into an on-chip chaining register. While a non-final block is in flight,
//   input is paused so the next block of that message sees the finished chain.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous reset, ACTIVE-HIGH (1 = reset)
//   block_in   padded message block, W0 = [511:480] ... W15 = [31:0]
//   valid_in   block_in / is_last valid this cycle
//   is_last    block is the final block of its message
//   pause      registered; 1 = input not accepted this cycle
//   hash_out   last final digest, H0 = [255:224] ... H7 = [31:0]
//   valid_out  one-cycle pulse when hash_out takes a new digest
// ---------------------------------------------------------------------------
module sha256_top (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [511:0] block_in,
    input  logic         valid_in,
    input  logic         is_last,
    output logic         pause,
    output logic [255:0] hash_out,
    output logic         valid_out
);

    typedef logic [31:0]       word_t;
    typedef logic [7:0][31:0]  vars_t;    // index 0 = a / H0 ... 7 = h / H7
    typedef logic [15:0][31:0] window_t;  // index 0 = W[t] ... 15 = W[t+15]

    typedef struct packed {
        logic    last;
        vars_t   v;
        window_t w;
        vars_t   h_in;
    } stage_t;

    // The stage after the last round no longer needs the schedule window.
    typedef struct packed {
        logic  last;
        vars_t v;
        vars_t h_in;
    } fin_t;

    localparam vars_t IV = {32'h5be0cd19, 32'h1f83d9ab, 32'h9b05688c, 32'h510e527f,
                            32'ha54ff53a, 32'h3c6ef372, 32'hbb67ae85, 32'h6a09e667};

    localparam word_t K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    // ---------------------------------------------------------------- helpers
    function automatic word_t rotr(input word_t x, input int unsigned n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic word_t bsig0(input word_t x);
        return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction

    function automatic word_t bsig1(input word_t x);
        return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction

    function automatic word_t ssig0(input word_t x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic word_t ssig1(input word_t x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    function automatic word_t ch(input word_t e, input word_t f, input word_t g);
        return (e & f) ^ (~e & g);
    endfunction

    function automatic word_t maj(input word_t a, input word_t b, input word_t c);
        return (a & b) ^ (a & c) ^ (b & c);
    endfunction

    // One compression round on a..h.
    function automatic vars_t round_vars(input vars_t s, input word_t k, input word_t w);
        vars_t r;
        word_t t1;
        word_t t2;
        t1   = s[7] + bsig1(s[4]) + ch(s[4], s[5], s[6]) + k + w;
        t2   = bsig0(s[0]) + maj(s[0], s[1], s[2]);
        r[0] = t1 + t2;
        r[1] = s[0];
        r[2] = s[1];
        r[3] = s[2];
        r[4] = s[3] + t1;
        r[5] = s[4];
        r[6] = s[5];
        r[7] = s[6];
        return r;
    endfunction

    // Slide the 16-word schedule window by one, appending W[t+16].
    function automatic window_t next_window(input window_t w);
        window_t r;
        r[14:0] = w[15:1];
        r[15]   = ssig1(w[14]) + w[9] + ssig0(w[1]) + w[0];
        return r;
    endfunction

    // ---------------------------------------------------------------- state
    stage_t       stage_q [64];
    fin_t         fin_q;
    logic [63:0]  vld_q;          // bit i = stage_q[i] holds a live block
    logic         fin_vld_q;
    logic         pause_q,       pause_d;
    logic         valid_out_q,   valid_out_d;
    logic [255:0] hash_q,        hash_d;
    vars_t        chain_q,       chain_d;
    logic         chain_valid_q, chain_valid_d;

    logic         accept;
    stage_t       stage_in;
    vars_t        h_out;

    assign accept = valid_in & ~pause_q;

    // Load a fresh block into the pipeline entry.
    always_comb begin
        // NOTE: every always_comb output gets a full default first so no path leaves it unassigned (no latch).
        stage_in      = '0;
        stage_in.last = is_last;
        stage_in.h_in = chain_valid_q ? chain_q : IV;
        stage_in.v    = stage_in.h_in;
        for (int j = 0; j < 16; j++) begin
            stage_in.w[j] = block_in[511 - 32*j -: 32];
        end
    end

    // Datapath: round i takes stage_q[i] into stage_q[i+1]; round 63 lands in fin_q.
    // NOTE: the wide datapath registers carry no reset; only the valid bits decide whether their contents matter.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all stages update from pre-edge values.
        stage_q[0] <= stage_in;
        for (int i = 0; i < 63; i++) begin
            stage_q[i+1].last <= stage_q[i].last;
            stage_q[i+1].h_in <= stage_q[i].h_in;
            stage_q[i+1].v    <= round_vars(stage_q[i].v, K[i], stage_q[i].w[0]);
            stage_q[i+1].w    <= next_window(stage_q[i].w);
        end
        fin_q.last <= stage_q[63].last;
        fin_q.h_in <= stage_q[63].h_in;
        fin_q.v    <= round_vars(stage_q[63].v, K[63], stage_q[63].w[0]);
    end

    // Final addition, chaining and pause control.
    always_comb begin
        pause_d       = pause_q;
        valid_out_d   = 1'b0;
        hash_d        = hash_q;
        chain_d       = chain_q;
        chain_valid_d = chain_valid_q;
        for (int j = 0; j < 8; j++) begin
            h_out[j] = fin_q.h_in[j] + fin_q.v[j];
        end

        if (fin_vld_q) begin
            if (fin_q.last) begin
                hash_d        = {h_out[0], h_out[1], h_out[2], h_out[3],
                                 h_out[4], h_out[5], h_out[6], h_out[7]};
                valid_out_d   = 1'b1;
                chain_valid_d = 1'b0;
            end else begin
                chain_d       = h_out;
                chain_valid_d = 1'b1;
                pause_d       = 1'b0;
            end
        end

        // A final block has already consumed the chain on entry, so drop it
        // right away: a new message may start on the very next cycle and must
        // begin from IV rather than from a stale chain.
        if (accept) begin
            if (is_last) begin
                chain_valid_d = 1'b0;
            end else begin
                pause_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            vld_q         <= '0;
            fin_vld_q     <= 1'b0;
            pause_q       <= 1'b0;
            valid_out_q   <= 1'b0;
            hash_q        <= '0;
            chain_q       <= '0;
            chain_valid_q <= 1'b0;
        end else begin
            vld_q         <= {vld_q[62:0], accept};
            fin_vld_q     <= vld_q[63];
            pause_q       <= pause_d;
            valid_out_q   <= valid_out_d;
            hash_q        <= hash_d;
            chain_q       <= chain_d;
            chain_valid_q <= chain_valid_d;
        end
    end

    assign pause     = pause_q;
    assign hash_out  = hash_q;
    assign valid_out = valid_out_q;

endmodule

// File: tb/tb_sha256_top.sv
// ---------------------------------------------------------------------------
// tb_sha256_top
//   Self-checking bench for sha256_top. Known-answer blocks are kept in a
//   table; digests and their expected arrival cycles go into a scoreboard
//   queue when a block is driven and are popped by a monitor on valid_out.
//   Hand-written sequences cover pause hold/drop, chaining and mid-flight
//   reset.
// ---------------------------------------------------------------------------
module tb_sha256_top;

    localparam logic [511:0] BLK_ABC   = {32'h61626380, 448'h0, 32'h00000018};
    localparam logic [511:0] BLK_EMPTY = {32'h80000000, 480'h0};
    localparam logic [511:0] BLK_M1    = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                                          32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                                          32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                                          32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
    localparam logic [511:0] BLK_M2    = {480'h0, 32'h000001c0};

    localparam logic [255:0] DIG_ABC   = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    localparam logic [255:0] DIG_EMPTY = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
    localparam logic [255:0] DIG_M     = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

    // Block accepted at edge T -> digest registered at edge T+65.
    localparam int LATENCY = 65;
    // A non-final block holds pause high for 65 sampled cycles.
    localparam int PAUSE_CYCLES = 65;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [511:0] block_in;
    logic         valid_in;
    logic         is_last;
    logic         pause;
    logic [255:0] hash_out;
    logic         valid_out;

    always #5 clk = ~clk;

    sha256_top dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .block_in  (block_in),
        .valid_in  (valid_in),
        .is_last   (is_last),
        .pause     (pause),
        .hash_out  (hash_out),
        .valid_out (valid_out)
    );

    typedef struct {
        logic [255:0] hash;
        int           cyc;
    } exp_t;

    typedef struct {
        logic [511:0] block;
        logic         last;
        logic [255:0] digest;
    } vec_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_pulses = 0;
    int   cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Called just after a negedge; the block meets the next rising edge.
    task automatic drive(input logic [511:0] blk, input logic last, input logic [255:0] digest,
                         input logic expect_out);
        block_in = blk;
        is_last  = last;
        valid_in = 1'b1;
        if (expect_out) sb_q.push_back('{hash: digest, cyc: cyc + 1 + LATENCY});
        @(negedge clk);
        valid_in = 1'b0;
        is_last  = 1'b0;
    endtask

    // Keep offering junk while pause is high; returns how many cycles it was high.
    task automatic hold_during_pause(output int n_high);
        n_high = 0;
        for (int k = 0; k < 200; k++) begin
            if (pause !== 1'b1) break;
            n_high++;
            block_in = {16{32'hdeadbeef ^ k}};
            is_last  = k[0];
            valid_in = 1'b1;
            @(negedge clk);
        end
        valid_in = 1'b0;
        is_last  = 1'b0;
    endtask

    task automatic drain();
        for (int k = 0; k < 200 && sb_q.size() != 0; k++) @(negedge clk);
        check("scoreboard_drained", 256'(sb_q.size()), 256'(0));
    endtask

    // Monitor: every valid_out pulse must match the oldest expected digest.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (valid_out === 1'b1) begin
                n_pulses++;
                check("pulse_expected", 256'(sb_q.size() > 0), 256'(1));
                if (sb_q.size() > 0) begin
                    e = sb_q.pop_front();
                    check("digest", hash_out, e.hash);
                    check("latency_cycle", 256'(cyc), 256'(e.cyc));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[7];
        int   n_high;

        vecs[0] = '{block: BLK_ABC,   last: 1'b1, digest: DIG_ABC};
        vecs[1] = '{block: BLK_EMPTY, last: 1'b1, digest: DIG_EMPTY};
        vecs[2] = '{block: BLK_ABC,   last: 1'b1, digest: DIG_ABC};
        vecs[3] = '{block: BLK_EMPTY, last: 1'b1, digest: DIG_EMPTY};
        vecs[4] = '{block: BLK_ABC,   last: 1'b1, digest: DIG_ABC};
        vecs[5] = '{block: BLK_EMPTY, last: 1'b1, digest: DIG_EMPTY};
        vecs[6] = '{block: BLK_M1,    last: 1'b0, digest: '0};

        rst_n    = 1'b1;
        valid_in = 1'b0;
        is_last  = 1'b0;
        block_in = '0;
        repeat (3) @(negedge clk);
        check("reset_pause",     256'(pause),     256'(0));
        check("reset_valid_out", 256'(valid_out), 256'(0));
        check("reset_hash_out",  hash_out,        256'(0));
        rst_n = 1'b0;
        @(negedge clk);

        // Back-to-back single-block messages, then the first block of a
        // two-block message right behind a final block.
        foreach (vecs[i]) begin
            drive(vecs[i].block, vecs[i].last, vecs[i].digest, vecs[i].last);
            check("pause_after_accept", 256'(pause), 256'(!vecs[i].last));
        end

        // Blocks offered while paused must be dropped.
        hold_during_pause(n_high);
        check("pause_cycles_m1", 256'(n_high), 256'(PAUSE_CYCLES));
        drive(BLK_M2, 1'b1, DIG_M, 1'b1);

        // New message directly after a final block must start from IV.
        drive(BLK_M1, 1'b0, '0, 1'b0);
        hold_during_pause(n_high);
        check("pause_cycles_m1_again", 256'(n_high), 256'(PAUSE_CYCLES));
        drive(BLK_M2, 1'b1, DIG_M, 1'b1);
        drain();

        // Reset with blocks in flight: nothing may emerge afterwards.
        drive(BLK_ABC, 1'b1, '0, 1'b0);
        drive(BLK_M1,  1'b0, '0, 1'b0);
        repeat (20) @(negedge clk);
        #2 rst_n = 1'b1;
        #1;
        check("async_reset_pause",     256'(pause),     256'(0));
        check("async_reset_valid_out", 256'(valid_out), 256'(0));
        check("async_reset_hash_out",  hash_out,        256'(0));
        @(negedge clk);
        rst_n = 1'b0;
        repeat (80) @(negedge clk);
        check("post_reset_hash_out", hash_out,    256'(0));
        check("post_reset_pause",    256'(pause), 256'(0));

        // First block after reset starts from IV.
        drive(BLK_ABC, 1'b1, DIG_ABC, 1'b1);
        drain();
        check("total_pulses", 256'(n_pulses), 256'(9));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
